// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: frame tick from vblank, round FSM, paddle gating, ball control, scores.
// Optional pause feature enabled by defining PONG_PAUSE_EN.
module pong_game_ctrl #(
    parameter int unsigned WIN_SCORE    = 9,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 30
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       vblank_i,
    input  logic       start_i,
    input  logic       miss_l_i,
    input  logic       miss_r_i,
    input  logic       btn_up_l_i,
    input  logic       btn_dn_l_i,
    input  logic       btn_up_r_i,
    input  logic       btn_dn_r_i,
    output logic       up_l_o,
    output logic       down_l_o,
    output logic       up_r_o,
    output logic       down_r_o,
    output logic       ball_en_o,
    output logic       ball_rst_o,
    output logic       serve_dir_o,
    output logic [3:0] score_l_o,
    output logic [3:0] score_r_o,
    output logic       game_over_o,
    output logic       winner_o,
    output logic       frame_tick_o
);

    localparam logic [3:0] WinScore  = 4'(WIN_SCORE);
    localparam logic [7:0] ServeLoad = 8'(SERVE_FRAMES);
    localparam logic [7:0] PointLoad = 8'(POINT_FRAMES);

    typedef enum logic [2:0] {
        StIdle,
        StServe,
        StPlay,
        StPoint,
`ifdef PONG_PAUSE_EN
        StPause,
`endif
        StOver
    } state_e;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // vblank synchronizer/edge detect and start edge detect
    logic vb_sync1_q, vb_sync2_q, vb_prev_q, tick_q;
    logic start_q, start_prev_q, start_edge_q;

    // FSM state and registered outputs
    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] score_l_q, score_l_d, score_r_q, score_r_d;
    logic       serve_dir_q, serve_dir_d;
    logic       winner_q, winner_d;
    logic       ball_rst_q, ball_rst_d;
    logic       ball_en_q, game_over_q;
    logic       up_l_q, down_l_q, up_r_q, down_r_q;
    logic       move_en;

    // Input conditioning: 2-flop vblank sync plus edge register, start rising-edge pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vb_sync1_q   <= 1'b0;
            vb_sync2_q   <= 1'b0;
            vb_prev_q    <= 1'b0;
            tick_q       <= 1'b0;
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
            start_edge_q <= 1'b0;
        end else begin
            vb_sync1_q   <= vblank_i;
            vb_sync2_q   <= vb_sync1_q;
            vb_prev_q    <= vb_sync2_q;
            tick_q       <= vb_sync2_q & ~vb_prev_q;
            start_q      <= start_i;
            start_prev_q <= start_q;
            start_edge_q <= start_q & ~start_prev_q;
        end
    end

    // Round sequencing: next state, frame counter, scores and serve direction
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        ball_rst_d  = 1'b0;
        case (state_q)
            StIdle, StOver: begin
                if (start_edge_q) begin
                    score_l_d  = 4'd0;
                    score_r_d  = 4'd0;
                    winner_d   = 1'b0;
                    ball_rst_d = 1'b1;
                    cnt_d      = ServeLoad;
                    state_d    = StServe;
                end
            end
            StServe: begin
                if (tick_q) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = StPlay;
                    end
                end
            end
            StPlay: begin
`ifdef PONG_PAUSE_EN
                if (start_edge_q) begin
                    state_d = StPause;
                end else
`endif
                if (miss_l_i || miss_r_i) begin
                    state_d = StPoint;
                    cnt_d   = PointLoad;
                    // A double miss is a draw: no score, serve side kept
                    if (miss_l_i && !miss_r_i) begin
                        score_r_d   = sat_inc(score_r_q);
                        serve_dir_d = 1'b0;
                    end else if (miss_r_i && !miss_l_i) begin
                        score_l_d   = sat_inc(score_l_q);
                        serve_dir_d = 1'b1;
                    end
                end
            end
            StPoint: begin
                if (tick_q) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        if (score_l_q == WinScore || score_r_q == WinScore) begin
                            state_d  = StOver;
                            winner_d = (score_l_q != WinScore);
                        end else begin
                            ball_rst_d = 1'b1;
                            cnt_d      = ServeLoad;
                            state_d    = StServe;
                        end
                    end
                end
            end
`ifdef PONG_PAUSE_EN
            StPause: begin
                if (start_edge_q) begin
                    state_d = StPlay;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    assign move_en = (state_d == StServe) || (state_d == StPlay);

    // State register with outputs registered from the next state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            score_l_q   <= 4'd0;
            score_r_q   <= 4'd0;
            serve_dir_q <= 1'b0;
            winner_q    <= 1'b0;
            ball_rst_q  <= 1'b0;
            ball_en_q   <= 1'b0;
            game_over_q <= 1'b0;
            up_l_q      <= 1'b0;
            down_l_q    <= 1'b0;
            up_r_q      <= 1'b0;
            down_r_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            serve_dir_q <= serve_dir_d;
            winner_q    <= winner_d;
            ball_rst_q  <= ball_rst_d;
            ball_en_q   <= (state_d == StPlay);
            game_over_q <= (state_d == StOver);
            up_l_q      <= move_en & btn_up_l_i & ~btn_dn_l_i;
            down_l_q    <= move_en & btn_dn_l_i & ~btn_up_l_i;
            up_r_q      <= move_en & btn_up_r_i & ~btn_dn_r_i;
            down_r_q    <= move_en & btn_dn_r_i & ~btn_up_r_i;
        end
    end

    assign up_l_o       = up_l_q;
    assign down_l_o     = down_l_q;
    assign up_r_o       = up_r_q;
    assign down_r_o     = down_r_q;
    assign ball_en_o    = ball_en_q;
    assign ball_rst_o   = ball_rst_q;
    assign serve_dir_o  = serve_dir_q;
    assign score_l_o    = score_l_q;
    assign score_r_o    = score_r_q;
    assign game_over_o  = game_over_q;
    assign winner_o     = winner_q;
    assign frame_tick_o = tick_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with WIN_SCORE=2, SERVE_FRAMES=3, POINT_FRAMES=2.
module tb_pong_game_ctrl;

    logic       clk, rst, vblank, start, miss_l, miss_r;
    logic       btn_up_l, btn_dn_l, btn_up_r, btn_dn_r;
    logic       up_l, down_l, up_r, down_r, ball_en, ball_rst, serve_dir;
    logic [3:0] score_l, score_r;
    logic       game_over, winner, frame_tick;

    int n_checks = 0;
    int n_errors = 0;

    pong_game_ctrl #(
        .WIN_SCORE   (2),
        .SERVE_FRAMES(3),
        .POINT_FRAMES(2)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .vblank_i    (vblank),
        .start_i     (start),
        .miss_l_i    (miss_l),
        .miss_r_i    (miss_r),
        .btn_up_l_i  (btn_up_l),
        .btn_dn_l_i  (btn_dn_l),
        .btn_up_r_i  (btn_up_r),
        .btn_dn_r_i  (btn_dn_r),
        .up_l_o      (up_l),
        .down_l_o    (down_l),
        .up_r_o      (up_r),
        .down_r_o    (down_r),
        .ball_en_o   (ball_en),
        .ball_rst_o  (ball_rst),
        .serve_dir_o (serve_dir),
        .score_l_o   (score_l),
        .score_r_o   (score_r),
        .game_over_o (game_over),
        .winner_o    (winner),
        .frame_tick_o(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, leaving time just past the last edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raise vblank; returns right after the edge where the FSM consumes the tick
    task automatic vb_rise();
        vblank = 1'b1;
        step(4);
    endtask

    task automatic vb_fall();
        vblank = 1'b0;
        step(3);
    endtask

    task automatic frame();
        vb_rise();
        vb_fall();
    endtask

    task automatic pulse_miss(input logic l, input logic r);
        miss_l = l;
        miss_r = r;
        step(1);
        miss_l = 1'b0;
        miss_r = 1'b0;
    endtask

    initial begin
        rst = 1'b1; vblank = 1'b0; start = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
        btn_up_l = 1'b0; btn_dn_l = 1'b0; btn_up_r = 1'b0; btn_dn_r = 1'b0;
        step(3);
        check_eq("rst_score_l", score_l, 0);
        check_eq("rst_score_r", score_r, 0);
        check_eq("rst_ball_en", ball_en, 0);
        check_eq("rst_game_over", game_over, 0);
        check_eq("rst_frame_tick", frame_tick, 0);
        rst = 1'b0;
        step(2);

        // Frame tick latency and width
        vblank = 1'b1;
        step(1); check_eq("tick_edge1", frame_tick, 0);
        step(1); check_eq("tick_edge2", frame_tick, 0);
        step(1); check_eq("tick_edge3", frame_tick, 1);
        step(1); check_eq("tick_one_cycle", frame_tick, 0);
        vblank = 1'b0;
        step(3);

        // Start from IDLE
        start = 1'b1;
        step(2); check_eq("start_rst_early", ball_rst, 0);
        step(1); check_eq("start_ball_rst", ball_rst, 1);
        check_eq("serve_ball_en", ball_en, 0);
        start = 1'b0;
        step(1); check_eq("start_ball_rst_end", ball_rst, 0);

        btn_up_r = 1'b1;
        step(1); check_eq("serve_up_r", up_r, 1);
        btn_up_r = 1'b0;
        step(1);

        frame(); frame();
        check_eq("serve_wait_ball_en", ball_en, 0);
        frame();
        check_eq("play_ball_en", ball_en, 1);

        // Paddle gating in PLAY
        btn_up_l = 1'b1; btn_dn_l = 1'b1; btn_dn_r = 1'b1;
        step(1);
        check_eq("both_up_l", up_l, 0);
        check_eq("both_down_l", down_l, 0);
        check_eq("play_down_r", down_r, 1);
        btn_up_l = 1'b0; btn_dn_l = 1'b0; btn_dn_r = 1'b0;
        step(1);

        // Left miss
        pulse_miss(1'b1, 1'b0);
        check_eq("miss_l_score_r", score_r, 1);
        check_eq("miss_l_score_l", score_l, 0);
        check_eq("miss_l_serve_dir", serve_dir, 0);
        check_eq("miss_l_ball_en", ball_en, 0);
        btn_up_r = 1'b1;
        step(1); check_eq("point_up_r", up_r, 0);
        btn_up_r = 1'b0;
        frame();
        vb_rise();
        check_eq("point_ball_rst", ball_rst, 1);
        vb_fall();
        check_eq("reserve_ball_en", ball_en, 0);
        frame(); frame(); frame();
        check_eq("replay_ball_en", ball_en, 1);

        // Right miss
        pulse_miss(1'b0, 1'b1);
        check_eq("miss_r_score_l", score_l, 1);
        check_eq("miss_r_serve_dir", serve_dir, 1);
        frame(); frame();
        pulse_miss(1'b1, 1'b0);
        check_eq("serve_miss_ignored", score_r, 1);
        frame(); frame(); frame();
        check_eq("play3_ball_en", ball_en, 1);

        // Simultaneous misses
        pulse_miss(1'b1, 1'b1);
        check_eq("dbl_score_l", score_l, 1);
        check_eq("dbl_score_r", score_r, 1);
        check_eq("dbl_serve_dir", serve_dir, 1);
        check_eq("dbl_ball_en", ball_en, 0);
        frame(); frame();
        frame(); frame(); frame();
        check_eq("play4_ball_en", ball_en, 1);

        // Winning miss
        pulse_miss(1'b0, 1'b1);
        check_eq("win_score_l", score_l, 2);
        check_eq("win_pending_over", game_over, 0);
        frame();
        vb_rise();
        check_eq("over_game_over", game_over, 1);
        check_eq("over_winner", winner, 0);
        check_eq("over_ball_rst", ball_rst, 0);
        vb_fall();
        pulse_miss(1'b0, 1'b1);
        check_eq("over_miss_ignored", score_l, 2);

        // Restart from OVER
        start = 1'b1;
        step(3);
        check_eq("restart_score_l", score_l, 0);
        check_eq("restart_score_r", score_r, 0);
        check_eq("restart_game_over", game_over, 0);
        check_eq("restart_ball_rst", ball_rst, 1);
        start = 1'b0;
        step(2);
        frame(); frame(); frame();
        check_eq("play5_ball_en", ball_en, 1);

`ifdef PONG_PAUSE_EN
        start = 1'b1; step(3);
        check_eq("pause_ball_en", ball_en, 0);
        start = 1'b0; step(2);
        pulse_miss(1'b0, 1'b1);
        check_eq("pause_miss_ignored", score_l, 0);
        start = 1'b1; step(3);
        check_eq("resume_ball_en", ball_en, 1);
        check_eq("resume_score_l", score_l, 0);
        start = 1'b0; step(2);
`else
        start = 1'b1; step(3);
        check_eq("play_start_ignored", ball_en, 1);
        check_eq("play_start_no_rst", ball_rst, 0);
        start = 1'b0; step(2);
`endif

        // Asynchronous reset mid-PLAY
        btn_up_l = 1'b1;
        step(1); check_eq("pre_rst_up_l", up_l, 1);
        rst = 1'b1;
        #1;
        check_eq("async_rst_ball_en", ball_en, 0);
        check_eq("async_rst_up_l", up_l, 0);
        check_eq("async_rst_serve_dir", serve_dir, 0);
        btn_up_l = 1'b0;
        step(1);
        rst = 1'b0;
        step(2);
        frame();
        check_eq("idle_ignores_tick", ball_en, 0);
        check_eq("idle_no_ball_rst", ball_rst, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_errors);
        $finish;
    end

endmodule
